// File: rtl/key_debounce_sync_pkg.sv
// Shared constants for the push-button conditioning block.
// ms_to_cycles() lets integrators size DEBOUNCE_CYCLES from a time in ms.
package key_pkg;

    localparam int unsigned CLK_HZ                  = 50_000_000;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500_000;

    // Integer cycles per ms (50 000 at the default clock), times ms.
    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/key_debounce_sync_debounce_bit.sv
// One key channel: a two-flop synchroniser, a stability counter, the
// accepted "pressed" level, and registered press/release pulses.
module debounce_bit
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int              CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             pressed_s;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_nxt;
    logic             press_nxt;
    logic             release_nxt;

    assign pressed_s = sync2 ^ ACTIVE_LOW;

    // The pulse is computed together with the level so both land in the
    // same register update; no edge detector on key_level is needed.
    always_comb begin
        cnt_nxt     = '0;
        level_nxt   = key_level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        if (pressed_s != key_level) begin
            if (cnt == CNT_MAX) begin
                level_nxt   = pressed_s;
                press_nxt   = pressed_s;
                release_nxt = ~pressed_s;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    // The synchroniser resets to the released level, so ending reset with
    // the key idle never looks like a transition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1       <= ACTIVE_LOW;
            sync2       <= ACTIVE_LOW;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            sync1       <= key_raw;
            sync2       <= sync1;
            cnt         <= cnt_nxt;
            key_level   <= level_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
        end
    end

endmodule

// File: rtl/key_debounce_sync.sv
// Conditions the raw push-button pins into a clean pressed-level vector for
// the input PIO, plus one-cycle press/release pulses for fabric logic.
module key_debounce_sync
    import key_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] key_level,
    output logic [WIDTH-1:0] key_press,
    output logic [WIDTH-1:0] key_release
);

    // Channels are fully independent; several may update on the same edge.
    for (genvar i = 0; i < WIDTH; i++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_debounce_bit (
            .clk         (clk),
            .reset_n     (reset_n),
            .key_raw     (key_raw[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i])
        );
    end

endmodule
